// File: rtl/lvt_pkg.sv
// Shared types and helpers for the live-value-table multi-port RAM.
// Optional feature macro used by the top: LVT_MULTIPORT_BYPASS_EN.
package lvt_pkg;

  // Sequencer states: INIT clears every bank and the LVT; RUN is normal operation.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } lvt_state_t;

  // Width of one LVT entry: enough bits to name a write port, never less than one.
  function automatic int lvt_w(input int ports);
    int bits;
    bits = $clog2(ports);
    return (bits < 1) ? 1 : bits;
  endfunction

  // True when an address lies inside a DEPTH-word memory. DEPTH need not be 2^n.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/lvt_multiport_ram_if.sv
// Bus bundle for lvt_multiport_ram: all write/read ports plus status flags.
interface lvt_multiport_ram_if #(
  parameter int WIDTH       = 32,
  parameter int AW          = 9,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8
);
  logic [WRITE_PORTS-1:0][AW-1:0]    wr_addr;
  logic [WRITE_PORTS-1:0]            wr_en;
  logic [WRITE_PORTS-1:0][WIDTH-1:0] wr_data;
  logic [READ_PORTS-1:0][AW-1:0]     rd_addr;
  logic [READ_PORTS-1:0]             rd_en;
  logic [READ_PORTS-1:0][WIDTH-1:0]  rd_data;
  logic [READ_PORTS-1:0]             rd_valid;
  logic                              ready;
  logic                              wr_conflict;

  modport master (
    output wr_addr, wr_en, wr_data, rd_addr, rd_en,
    input  rd_data, rd_valid, ready, wr_conflict
  );

  modport slave (
    input  wr_addr, wr_en, wr_data, rd_addr, rd_en,
    output rd_data, rd_valid, ready, wr_conflict
  );
endinterface

// File: rtl/lvt_sdp_bank.sv
// One simple dual-port bank: one write port, one registered read port with enable.
// Contents are deliberately not reset; the top-level sequencer clears them.
module lvt_sdp_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Memory write and read-first registered read; output holds when re_i is low.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lvt_multiport_ram.sv
// W-write / R-read multi-port RAM built from W x R dual-port banks and a
// live-value table recording which write port last wrote each address.
// Define LVT_MULTIPORT_BYPASS_EN for write-first forwarding on same-edge hits.
module lvt_multiport_ram
  import lvt_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 512,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  lvt_multiport_ram_if.slave  bus
);
  localparam int LW = lvt_w(WRITE_PORTS);

  lvt_state_t state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic run_s;

  logic [LW-1:0] lvt_q [DEPTH];

  logic [WRITE_PORTS-1:0]            wr_ok_s;
  logic [WRITE_PORTS-1:0]            wr_win_s;
  logic                              conflict_s;
  logic [WRITE_PORTS-1:0]            bank_we_s;
  logic [WRITE_PORTS-1:0][AW-1:0]    bank_waddr_s;
  logic [WRITE_PORTS-1:0][WIDTH-1:0] bank_wdata_s;
  logic [WIDTH-1:0]                  bank_rdata_s [WRITE_PORTS][READ_PORTS];

  logic [READ_PORTS-1:0]             rd_acc_s;
  logic [READ_PORTS-1:0]             rd_ok_s;
  logic [READ_PORTS-1:0]             rd_valid_q;
  logic [READ_PORTS-1:0]             zero_q;
  logic [LW-1:0]                     lvt_sel_q [READ_PORTS];
  logic                              wr_conflict_q;
  logic [READ_PORTS-1:0][WIDTH-1:0]  rd_data_s;

  assign run_s = (state_q == RUN);

  // Sequencer state and init counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Sequencer next state: sweep every address once, then run forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + AW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d    = INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // Write qualification and collision priority: the highest-index port wins.
  always_comb begin
    wr_ok_s    = '0;
    wr_win_s   = '0;
    conflict_s = 1'b0;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_ok_s[w] = run_s && bus.wr_en[w] && addr_in_range(32'(bus.wr_addr[w]), DEPTH);
    end
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_win_s[w] = wr_ok_s[w];
      for (int v = w + 1; v < WRITE_PORTS; v++) begin
        logic hit;
        hit         = wr_ok_s[w] && wr_ok_s[v] && (bus.wr_addr[w] == bus.wr_addr[v]);
        wr_win_s[w] = wr_win_s[w] & ~hit;
        conflict_s  = conflict_s | hit;
      end
    end
  end

  // Bank write steering: INIT writes zero at init_cnt everywhere, RUN uses the winners.
  always_comb begin
    for (int w = 0; w < WRITE_PORTS; w++) begin
      bank_we_s[w]    = run_s ? wr_win_s[w]     : 1'b1;
      bank_waddr_s[w] = run_s ? bus.wr_addr[w]  : init_cnt_q;
      bank_wdata_s[w] = run_s ? bus.wr_data[w]  : '0;
    end
  end

  // Read acceptance; out-of-range reads are accepted but never touch a bank.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_acc_s[r] = run_s && bus.rd_en[r];
      rd_ok_s[r]  = rd_acc_s[r] && addr_in_range(32'(bus.rd_addr[r]), DEPTH);
    end
  end

  genvar gw, gr;
  generate
    for (gw = 0; gw < WRITE_PORTS; gw++) begin : g_wr
      for (gr = 0; gr < READ_PORTS; gr++) begin : g_rd
        lvt_sdp_bank #(
          .WIDTH (WIDTH),
          .DEPTH (DEPTH),
          .AW    (AW)
        ) u_bank (
          .clk_i   (clk),
          .we_i    (bank_we_s[gw]),
          .waddr_i (bank_waddr_s[gw]),
          .wdata_i (bank_wdata_s[gw]),
          .re_i    (rd_ok_s[gr]),
          .raddr_i (bus.rd_addr[gr]),
          .rdata_o (bank_rdata_s[gw][gr])
        );
      end
    end
  endgenerate

  // LVT update: cleared during INIT, later the last (highest) accepted writer per address.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      lvt_q[init_cnt_q] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_ok_s[w]) begin
          lvt_q[bus.wr_addr[w]] <= LW'(w);
        end
      end
    end
  end

  // Read-side bookkeeping: valid pulse, zero override and LVT selection captured per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q    <= '0;
      zero_q        <= '1;
      wr_conflict_q <= 1'b0;
      for (int r = 0; r < READ_PORTS; r++) begin
        lvt_sel_q[r] <= '0;
      end
    end else begin
      wr_conflict_q <= conflict_s;
      rd_valid_q    <= rd_acc_s;
      for (int r = 0; r < READ_PORTS; r++) begin
        if (rd_acc_s[r]) begin
          zero_q[r]    <= ~rd_ok_s[r];
          lvt_sel_q[r] <= rd_ok_s[r] ? lvt_q[bus.rd_addr[r]] : '0;
        end
      end
    end
  end

`ifdef LVT_MULTIPORT_BYPASS_EN
  logic [READ_PORTS-1:0]            fwd_hit_s;
  logic [READ_PORTS-1:0][WIDTH-1:0] fwd_data_s;
  logic [READ_PORTS-1:0]            fwd_hit_q;
  logic [READ_PORTS-1:0][WIDTH-1:0] fwd_data_q;

  // Forwarding compare: the highest-index accepted write to the read address wins.
  always_comb begin
    fwd_hit_s  = '0;
    fwd_data_s = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        logic m;
        m             = wr_ok_s[w] && (bus.wr_addr[w] == bus.rd_addr[r]);
        fwd_hit_s[r]  = fwd_hit_s[r] | m;
        fwd_data_s[r] = m ? bus.wr_data[w] : fwd_data_s[r];
      end
    end
  end

  // Forwarding registers, updated only when the read is accepted so data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      for (int r = 0; r < READ_PORTS; r++) begin
        if (rd_acc_s[r]) begin
          fwd_hit_q[r]  <= fwd_hit_s[r];
          fwd_data_q[r] <= fwd_data_s[r];
        end
      end
    end
  end
`endif

  // Output mux: zero override, optional forwarded word, else the bank named by the LVT.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_data_s[r] = bank_rdata_s[lvt_sel_q[r]][r];
`ifdef LVT_MULTIPORT_BYPASS_EN
      if (fwd_hit_q[r]) begin
        rd_data_s[r] = fwd_data_q[r];
      end else begin
        rd_data_s[r] = bank_rdata_s[lvt_sel_q[r]][r];
      end
`endif
      if (zero_q[r]) begin
        rd_data_s[r] = '0;
      end else begin
        rd_data_s[r] = rd_data_s[r];
      end
    end
  end

  assign bus.rd_data     = rd_data_s;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.ready       = run_s;
  assign bus.wr_conflict = wr_conflict_q;

endmodule
